data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of storage bytes, a power of two.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait cycles between request accept and response, range 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit, meaning the initiator requests an access.
REQ-006 The block SHALL have port we, input, 1 bit, meaning 1 = store and 0 = load.
REQ-007 The block SHALL have port size, input, 2 bits, encoded 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 The block SHALL have port sign_ext, input, 1 bit, meaning sign-extend a byte or halfword load.
REQ-009 The block SHALL have port addr, input, 32 bits, the byte address.
REQ-010 The block SHALL have port wdata, input, 32 bits, the store data, right-justified.
REQ-011 The block SHALL have port ready, output, 1 bit, a one-cycle response strobe.
REQ-012 The block SHALL have port rdata, output, 32 bits, the load result, valid while ready=1.
REQ-013 The block SHALL have port busy, output, 1 bit, high from request accept until the response cycle inclusive.
REQ-014 The block SHALL have port err, output, 1 bit, the access-fault flag (see Configuration).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 In IDLE with req=1, the block SHALL latch we, size, sign_ext, addr and wdata, load the wait counter with LATENCY, and move to WAIT; if LATENCY=0 it SHALL move directly to RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP in the cycle after the counter reaches 1.
REQ-018 In RESP, the block SHALL assert ready for exactly one cycle and then return to IDLE.
REQ-019 The response cycle SHALL be LATENCY+1 cycles after the accept edge.
REQ-020 A req asserted outside IDLE SHALL be ignored and not queued, and it SHALL NOT alter any latched field.
REQ-021 Storage SHALL be big-endian: the byte at the lowest address maps to the most-significant byte of the halfword or word.
REQ-022 The effective byte address SHALL be addr modulo DEPTH; multi-byte accesses SHALL wrap modulo DEPTH (for example, a word at DEPTH-2 touches bytes DEPTH-2, DEPTH-1, 0 and 1).
REQ-023 A store SHALL commit its bytes on the RESP-cycle edge: size byte writes wdata[7:0], size half writes wdata[15:0], size word writes all 32 bits.
REQ-024 A load SHALL drive rdata during RESP: zero-extended when sign_ext=0, sign-extended from bit 7 or bit 15 when sign_ext=1.
REQ-025 rdata SHALL be 0 whenever ready=0 and during a store response.
REQ-026 Load data SHALL reflect all stores committed in earlier transactions.

Reset
REQ-027 While reset=0, the FSM SHALL be in IDLE, the counter SHALL be 0, and ready, busy, err and rdata SHALL be 0.
REQ-028 Reset SHALL NOT clear storage contents.
REQ-029 Reset asserted mid-transaction SHALL abort the transaction, produce no ready, and leave any pending store uncommitted.

Configuration
REQ-030 With macro DATA_MEM_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL complete with ready=1 and err=1, perform no store, and return rdata=0.
REQ-031 With macro DATA_MEM_MISALIGN_TRAP_EN undefined, misaligned accesses SHALL proceed byte-wise per REQ-021/REQ-022, and err SHALL be tied to 0.

Structure
REQ-032 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-033 Byte storage SHALL be the sub-module data_mem_array: DEPTH bytes, four byte-enabled write ports, and four asynchronous read ports, addressed a..a+3 modulo DEPTH.

Verification
REQ-034 Scenario: with LATENCY=2, a word store of 0xDEADBEEF to addr 56 SHALL give ready 3 cycles after accept, and bytes 56..59 SHALL hold DE, AD, BE, EF.
REQ-035 Scenario: after REQ-034, a byte load at 57 with sign_ext=1 SHALL return 0xFFFFFFAD, and a halfword load at 58 with sign_ext=0 SHALL return 0x0000BEEF.
REQ-036 Scenario: with LATENCY=0, back-to-back req held high SHALL accept every second cycle, with ready alternating 1 and 0.
REQ-037 Scenario: a word store of 0x11223344 at addr 254 with DEPTH=256 SHALL write bytes 254, 255, 0 and 1 as 11, 22, 33, 44.
REQ-038 Scenario: reset pulled low during WAIT of a store SHALL produce no ready, leave the old memory byte unchanged, and return busy to 0 immediately.
REQ-039 Scenario: with the trap macro defined, a word load at addr 2 SHALL return err=1 and rdata=0; with the trap macro undefined, the same access SHALL return the bytes 2..5 big-endian and err=0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: size encodings,
// FSM state type, latched request record and the alignment rule.
package data_mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Halfwords need addr[0]=0, words (and size 11) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    if (size == SZ_HALF) return a[0];
    if (size[1])         return |a;
    return 1'b0;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte storage: DEPTH bytes, four byte lanes at a, a+1, a+2, a+3 (mod DEPTH).
// Lane 0 is the lowest address. Reads are asynchronous; contents have no reset.
module data_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [AW-1:0]       addr,
  input  logic [3:0]          be,
  input  logic [3:0][7:0]     wdata,
  output logic [3:0][7:0]     rdata
);

  logic [7:0]         mem [DEPTH];
  logic [3:0][AW-1:0] lane_addr;

  // Per-lane address wraps naturally in AW bits since DEPTH is a power of two.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane_addr[k] = addr + AW'(k);
    assign rdata[k]     = mem[lane_addr[k]];
  end

  // Byte-enabled writes, one per lane.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (be[k]) mem[lane_addr[k]] <= wdata[k];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder over a big-endian byte array.
// Optional misalignment trap: define DATA_MEM_MISALIGN_TRAP_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  mem_req_t       lat;
  logic           trap;
  logic           wr_en;
  logic [3:0]     be;
  logic [3:0][7:0] wlane, rlane;
  logic [31:0]    ld;
  logic           unused_addr;

  assign unused_addr = ^lat.addr[31:AW];

  // State, wait counter and request latch; fields only load on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req)
        lat <= '{we: we, size: size, sign_ext: sign_ext, addr: addr, wdata: wdata};
    end
  end

  // Next state: counter leaves WAIT the cycle after it reads 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req) begin
        cnt_nxt   = 4'(LATENCY);
        state_nxt = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: if (cnt == 4'd1) begin
        cnt_nxt   = '0;
        state_nxt = RESP;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign trap = is_misaligned(lat.size, lat.addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign wr_en = (state == RESP) && lat.we && !trap;

  // Big-endian lane mapping of right-justified store data.
  always_comb begin
    be    = '0;
    wlane = '0;
    case (lat.size)
      SZ_BYTE: begin
        be       = 4'b0001;
        wlane[0] = lat.wdata[7:0];
      end
      SZ_HALF: begin
        be       = 4'b0011;
        wlane[0] = lat.wdata[15:8];
        wlane[1] = lat.wdata[7:0];
      end
      default: begin
        be = 4'b1111;
        for (int k = 0; k < 4; k++) wlane[k] = lat.wdata[31-8*k -: 8];
      end
    endcase
    if (!wr_en) be = '0;
  end

  data_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .addr  (lat.addr[AW-1:0]),
    .be    (be),
    .wdata (wlane),
    .rdata (rlane)
  );

  // Load assembly with optional sign extension; zero outside a load response.
  always_comb begin
    case (lat.size)
      SZ_BYTE: ld = {{24{lat.sign_ext & rlane[0][7]}}, rlane[0]};
      SZ_HALF: ld = {{16{lat.sign_ext & rlane[0][7]}}, rlane[0], rlane[1]};
      default: ld = {rlane[0], rlane[1], rlane[2], rlane[3]};
    endcase
    rdata = '0;
    if (state == RESP && !lat.we && !trap) rdata = ld;
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = (state == RESP) && trap;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (LATENCY=2 and LATENCY=0 instances).
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req, req0, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, busy, err, ready0, busy0, err0;
  logic [31:0] rdata, rdata0;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mref [256];
  logic [31:0] rd;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .rdata(rdata), .busy(busy), .err(err));

  data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready0), .rdata(rdata0), .busy(busy0), .err(err0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic trap_expected(input logic [1:0] sz, input logic [31:0] a);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    return (a % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
    int n = nbytes(sz);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(mref[int'((a + 32'(i)) % 256)]);
    if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) mref[int'((a + 32'(i)) % 256)] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  // One complete transaction on the LATENCY=2 instance; starts and ends at posedge+1 in IDLE.
  task automatic access(input logic we_i, input logic [1:0] sz_i, input logic sx_i,
                        input logic [31:0] a_i, input logic [31:0] d_i, input string tag,
                        output logic [31:0] rd_o);
    int n = 0;
    logic mis;
    req = 1'b1; we = we_i; size = sz_i; sign_ext = sx_i; addr = a_i; wdata = d_i;
    @(posedge clk); #1;
    req = 1'b0;
    while (!ready && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, 32'(n), 32'd2);
    mis = trap_expected(sz_i, a_i);
    check({tag, " rdata"}, rdata, (we_i || mis) ? 32'h0 : model_load(sz_i, sx_i, a_i));
    check({tag, " err"}, {31'b0, err}, {31'b0, mis});
    check({tag, " busy"}, {31'b0, busy}, 32'd1);
    rd_o = rdata;
    if (we_i && !mis) model_store(sz_i, a_i, d_i);
    @(posedge clk); #1;
    check({tag, " ready off"}, {31'b0, ready}, 32'd0);
    check({tag, " idle"}, {30'b0, busy, err} | rdata, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; size = SZ_BYTE;
    sign_ext = 1'b0; addr = '0; wdata = '0;
    #12;
    check("reset outs", {29'b0, ready, busy, err} | rdata, 32'd0);
    check("reset outs0", {29'b0, ready0, busy0, err0} | rdata0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill the whole array so every later load is defined.
    for (int i = 0; i < 64; i++) access(1'b1, SZ_WORD, 1'b0, 32'(i * 4), $urandom, "init", rd);

    // Word store at 56, byte readback, then signed/unsigned sub-word loads.
    access(1'b1, SZ_WORD, 1'b0, 32'd56, 32'hDEADBEEF, "st56", rd);
    check("st56 rdata zero", rd, 32'h0);
    access(1'b0, SZ_BYTE, 1'b0, 32'd56, 0, "b56", rd); check("b56 const", rd, 32'hDE);
    access(1'b0, SZ_BYTE, 1'b0, 32'd57, 0, "b57", rd); check("b57 const", rd, 32'hAD);
    access(1'b0, SZ_BYTE, 1'b0, 32'd58, 0, "b58", rd); check("b58 const", rd, 32'hBE);
    access(1'b0, SZ_BYTE, 1'b0, 32'd59, 0, "b59", rd); check("b59 const", rd, 32'hEF);
    access(1'b0, SZ_BYTE, 1'b1, 32'd57, 0, "sb57", rd); check("sb57 const", rd, 32'hFFFFFFAD);
    access(1'b0, SZ_HALF, 1'b0, 32'd58, 0, "h58", rd); check("h58 const", rd, 32'h0000BEEF);

    // Wrapping word store at the top of the array.
    access(1'b1, SZ_WORD, 1'b0, 32'd254, 32'h11223344, "st254", rd);
    access(1'b0, SZ_BYTE, 1'b0, 32'd254, 0, "b254", rd); check("b254 const", rd, 32'h11);
    access(1'b0, SZ_BYTE, 1'b0, 32'd255, 0, "b255", rd); check("b255 const", rd, 32'h22);
    access(1'b0, SZ_BYTE, 1'b0, 32'd0,   0, "b0",   rd); check("b0 const",   rd, 32'h33);
    access(1'b0, SZ_BYTE, 1'b0, 32'd1,   0, "b1",   rd); check("b1 const",   rd, 32'h44);
    access(1'b0, SZ_BYTE, 1'b0, 32'd510, 0, "b510", rd); check("b510 const", rd, 32'h11);

    // Misaligned word load at 2.
    access(1'b1, SZ_WORD, 1'b0, 32'd0, 32'h00010203, "st0", rd);
    access(1'b1, SZ_WORD, 1'b0, 32'd4, 32'h04050607, "st4", rd);
    access(1'b0, SZ_WORD, 1'b0, 32'd2, 0, "w2", rd);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    check("w2 const", rd, 32'h0);
`else
    check("w2 const", rd, 32'h02030405);
`endif

    // req held high outside IDLE with different fields must be ignored.
    req = 1'b1; we = 1'b0; size = SZ_WORD; sign_ext = 1'b0; addr = 32'd100; wdata = '0;
    @(posedge clk); #1;
    we = 1'b1; addr = 32'd104; wdata = 32'hFFFFFFFF;
    n = 0;
    while (!ready && n < 20) begin @(posedge clk); #1; n++; end
    check("ign latency", 32'(n), 32'd2);
    check("ign rdata", rdata, model_load(SZ_WORD, 1'b0, 32'd100));
    req = 1'b0;
    @(posedge clk); #1;
    check("ign idle", {31'b0, busy}, 32'd0);
    access(1'b0, SZ_WORD, 1'b0, 32'd104, 0, "ign w104", rd);

    // Reset during WAIT of a store: no ready, no commit, busy drops at once.
    req = 1'b1; we = 1'b1; size = SZ_BYTE; addr = 32'd120; wdata = {24'b0, ~mref[120]};
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("rst busy before", {31'b0, busy}, 32'd1);
    reset = 1'b0; #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst ready", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst no ready", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    access(1'b0, SZ_BYTE, 1'b0, 32'd120, 0, "rst b120", rd);

    // LATENCY=0: held req accepts every second cycle.
    we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'd200; wdata = 32'h5A;
    req0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("l0 ready", {31'b0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("l0 busy", {31'b0, busy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("l0 rdata", rdata0, 32'h0);
    end
    req0 = 1'b0;
    @(posedge clk); #1;

    // Random traffic across sizes, sign modes, wrap and out-of-range addresses.
    for (int i = 0; i < 300; i++)
      access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, "rand", rd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
